// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ps2_pkg
// Description : Shared definitions for the PS/2 host transmit and receive
//               paths: FSM state encoding, default timing constants for a
//               25 MHz system clock, common command bytes and a frame helper.
// Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

  // Transmit FSM state encoding
  typedef logic [2:0] ps2_state_t;
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_INHIBIT = 3'd1;
  localparam logic [2:0] ST_REQ     = 3'd2;
  localparam logic [2:0] ST_SHIFT   = 3'd3;
  localparam logic [2:0] ST_RELEASE = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;
  localparam logic [2:0] ST_ERR     = 3'd6;

  // Default timing at 25 MHz
  localparam int PS2_INHIBIT_CYCLES       = 2500;    // 100 us clock inhibit
  localparam int PS2_START_TIMEOUT_CYCLES = 375000;  // 15 ms for device to start clocking
  localparam int PS2_XFER_TIMEOUT_CYCLES  = 50000;   // 2 ms for the whole frame + ACK
  localparam int PS2_CNT_W                = 19;

  // Frequently used keyboard command / response bytes
  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_RSP_ACK      = 8'hFA;

  // Host-to-device frame after the start bit: {stop, odd parity, data LSB..}
  function automatic logic [9:0] ps2_tx_frame(input logic [7:0] data);
    return {1'b1, ~^data, data};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_line_sync.sv
`default_nettype none
// ============================================================================
// Module      : ps2_line_sync
// Description : Two-flop synchronizers for the raw PS/2 clock and data pins
//               plus a registered clock falling-edge pulse. Shared by the
//               host transmitter and the keyboard receive path.
// Revision    : 1.0 - initial release
// Ports       : clk       - system clock
//               rst_n     - asynchronous active-low reset
//               ps2_clk   - raw PS/2 clock pin level
//               ps2_data  - raw PS/2 data pin level
//               sync_clk  - synchronized clock level
//               sync_data - synchronized data level
//               clk_fall  - one-cycle pulse, high in the first cycle that
//                           sync_clk reads 0 after reading 1
// ============================================================================
module ps2_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic sync_clk,
  output logic sync_data,
  output logic clk_fall
);

  logic clk_meta;
  logic data_meta;

  // Idle bus is high; resetting to 1 avoids a false edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_meta  <= 1'b1;
      sync_clk  <= 1'b1;
      data_meta <= 1'b1;
      sync_data <= 1'b1;
      clk_fall  <= 1'b0;
    end else begin
      clk_meta  <= ps2_clk;
      sync_clk  <= clk_meta;
      data_meta <= ps2_data;
      sync_data <= data_meta;
      // sync_clk is about to take clk_meta; flag the 1->0 step in advance
      // so the pulse lines up with the first low cycle of sync_clk.
      clk_fall  <= sync_clk & ~clk_meta;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module      : ps2_host_tx
// Description : PS/2 host-to-device transmitter. Sends one command byte with
//               the host-initiated sequence (clock inhibit, start bit,
//               device-clocked data/parity/stop, device ACK) and drives
//               open-drain enables for the shared PS2_CLK/PS2_DATA pins.
//               Optional macro PS2_TX_RETRY_EN: on timeout or NACK, resend
//               the latched byte up to two more times before reporting.
// Revision    : 1.0 - initial release
// Ports       : CLK_25MHZ   - system clock
//               RESET_N     - asynchronous active-low reset
//               TX_VALID    - command byte offered
//               TX_READY    - high only while idle
//               TX_DATA     - command byte
//               PS2_CLK     - raw clock pin level
//               PS2_DATA    - raw data pin level
//               PS2_CLK_OE  - 1 pulls clock low
//               PS2_DATA_OE - 1 pulls data low
//               BUSY        - transfer in progress, receiver ignores frames
//               TX_DONE     - one-cycle end-of-transfer pulse
//               TX_ERR      - with TX_DONE: 1 = timeout or NACK
// ============================================================================
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES       = PS2_INHIBIT_CYCLES,
  parameter int START_TIMEOUT_CYCLES = PS2_START_TIMEOUT_CYCLES,
  parameter int XFER_TIMEOUT_CYCLES  = PS2_XFER_TIMEOUT_CYCLES,
  parameter int CNT_W                = PS2_CNT_W
) (
  input  logic       CLK_25MHZ,
  input  logic       RESET_N,
  input  logic       TX_VALID,
  output logic       TX_READY,
  input  logic [7:0] TX_DATA,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  output logic       PS2_CLK_OE,
  output logic       PS2_DATA_OE,
  output logic       BUSY,
  output logic       TX_DONE,
  output logic       TX_ERR
);

  localparam logic [CNT_W-1:0] INH_PRE    = CNT_W'(INHIBIT_CYCLES - 2);
  localparam logic [CNT_W-1:0] INH_LAST   = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] XFER_LAST  = CNT_W'(XFER_TIMEOUT_CYCLES - 1);

  logic             sync_clk;
  logic             sync_data;
  logic             clk_fall;

  ps2_state_t       state;
  logic [CNT_W-1:0] timer;
  // Device falling edges seen after the first one (the first edge is the
  // one that moves REQ into SHIFT and presents data bit 0).
  logic [3:0]       edge_cnt;
  logic [3:0]       next_idx;
  logic [9:0]       frame;
  logic             clk_oe;
  logic             data_oe;
  logic             accept;
  logic             fail;
  logic             can_retry;

  ps2_line_sync u_sync (
    .clk       (CLK_25MHZ),
    .rst_n     (RESET_N),
    .ps2_clk   (PS2_CLK),
    .ps2_data  (PS2_DATA),
    .sync_clk  (sync_clk),
    .sync_data (sync_data),
    .clk_fall  (clk_fall)
  );

  assign accept   = TX_VALID && (state == ST_IDLE);
  assign next_idx = edge_cnt + 4'd1;

  // Timeout or NACK in the current cycle.
  always_comb begin
    fail = 1'b0;
    case (state)
      ST_REQ:     fail = !clk_fall && (timer == START_LAST);
      ST_SHIFT:   fail = (timer == XFER_LAST) ||
                         (clk_fall && (edge_cnt == 4'd9) && sync_data);
      ST_RELEASE: fail = (timer == XFER_LAST) && !(sync_clk && sync_data);
      default:    fail = 1'b0;
    endcase
  end

`ifdef PS2_TX_RETRY_EN
  logic [1:0] retry_cnt;

  assign can_retry = (retry_cnt != 2'd2);

  always_ff @(posedge CLK_25MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      retry_cnt <= 2'd0;
    end else if (accept) begin
      retry_cnt <= 2'd0;
    end else if (fail && can_retry) begin
      retry_cnt <= retry_cnt + 2'd1;
    end
  end
`else
  assign can_retry = 1'b0;
`endif

  always_ff @(posedge CLK_25MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= ST_IDLE;
      timer    <= '0;
      edge_cnt <= 4'd0;
      frame    <= 10'd0;
      clk_oe   <= 1'b0;
      data_oe  <= 1'b0;
    end else if (fail) begin
      timer   <= '0;
      data_oe <= 1'b0;
      if (can_retry) begin
        state  <= ST_INHIBIT;
        clk_oe <= 1'b1;
      end else begin
        state  <= ST_ERR;
        clk_oe <= 1'b0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          clk_oe  <= 1'b0;
          data_oe <= 1'b0;
          if (accept) begin
            frame  <= ps2_tx_frame(TX_DATA);
            state  <= ST_INHIBIT;
            timer  <= '0;
            clk_oe <= 1'b1;
          end
        end
        ST_INHIBIT: begin
          timer <= timer + 1'b1;
          // Start bit goes low during the final inhibit cycle.
          if (timer == INH_PRE) begin
            data_oe <= 1'b1;
          end
          if (timer == INH_LAST) begin
            state   <= ST_REQ;
            timer   <= '0;
            clk_oe  <= 1'b0;
            data_oe <= 1'b1;
          end
        end
        ST_REQ: begin
          timer <= timer + 1'b1;
          if (clk_fall) begin
            state    <= ST_SHIFT;
            timer    <= '0;
            edge_cnt <= 4'd0;
            data_oe  <= ~frame[0];
          end
        end
        ST_SHIFT: begin
          timer <= timer + 1'b1;
          if (clk_fall) begin
            if (edge_cnt == 4'd9) begin
              // ACK edge; a NACK was already routed through fail.
              state <= ST_RELEASE;
            end else begin
              data_oe <= ~frame[next_idx];
              if (edge_cnt != 4'hF) begin
                edge_cnt <= next_idx;
              end
            end
          end
        end
        ST_RELEASE: begin
          timer <= timer + 1'b1;
          if (sync_clk && sync_data) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        ST_ERR:  state <= ST_IDLE;
        default: begin
          state   <= ST_IDLE;
          clk_oe  <= 1'b0;
          data_oe <= 1'b0;
        end
      endcase
    end
  end

  assign PS2_CLK_OE  = clk_oe;
  assign PS2_DATA_OE = data_oe;
  assign TX_READY    = (state == ST_IDLE);
  assign BUSY        = (state != ST_IDLE);
  assign TX_DONE     = (state == ST_DONE) || (state == ST_ERR);
  assign TX_ERR      = (state == ST_ERR);

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_host_tx
// Description : Self-checking bench for ps2_host_tx with a PS/2 device model
//               (open-drain bus, device-generated clock, ACK/NACK control).
//               Timing parameters are scaled down to keep runs short.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_host_tx;

  localparam int INH   = 100;
  localparam int START = 1200;
  localparam int XFER  = 1500;
  localparam int HALF  = 30;
`ifdef PS2_TX_RETRY_EN
  localparam int NTRIES = 3;
`else
  localparam int NTRIES = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       clk_oe;
  logic       data_oe;
  logic       busy;
  logic       tx_done;
  logic       tx_err;
  logic       dev_clk_low;
  logic       dev_data_low;
  wire        ps2_clk_pin  = ~(clk_oe | dev_clk_low);
  wire        ps2_data_pin = ~(data_oe | dev_data_low);

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Monitor state
  int   done_cnt = 0, err_last = 0, done_cyc = 0, oe_at_done = 0;
  int   inh_rises = 0, inh_len_cur = 0, inh_len_last = 0, req_cyc = 0;
  int   busy_after = 0;
  logic prev_clk_oe = 1'b0, prev_done = 1'b0;

  // Device model state
  int dev_edges = 0;
  int dev_first_fall_cyc = 0;

  ps2_host_tx #(
    .INHIBIT_CYCLES       (INH),
    .START_TIMEOUT_CYCLES (START),
    .XFER_TIMEOUT_CYCLES  (XFER),
    .CNT_W                (19)
  ) dut (
    .CLK_25MHZ   (clk),
    .RESET_N     (rst_n),
    .TX_VALID    (tx_valid),
    .TX_READY    (tx_ready),
    .TX_DATA     (tx_data),
    .PS2_CLK     (ps2_clk_pin),
    .PS2_DATA    (ps2_data_pin),
    .PS2_CLK_OE  (clk_oe),
    .PS2_DATA_OE (data_oe),
    .BUSY        (busy),
    .TX_DONE     (tx_done),
    .TX_ERR      (tx_err)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (prev_done) busy_after = int'(busy);
    if (tx_done) begin
      done_cnt   = done_cnt + 1;
      err_last   = int'(tx_err);
      done_cyc   = cyc;
      oe_at_done = int'(clk_oe | data_oe);
    end
    if (clk_oe && !prev_clk_oe) begin
      inh_rises   = inh_rises + 1;
      inh_len_cur = 0;
    end
    if (clk_oe) inh_len_cur = inh_len_cur + 1;
    if (!clk_oe && prev_clk_oe) begin
      inh_len_last = inh_len_cur;
      req_cyc      = cyc;
    end
    prev_clk_oe = clk_oe;
    prev_done   = tx_done;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests = n_tests + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Offer a byte (called just after a negedge); drops VALID after accept.
  task automatic send(input logic [7:0] b, output bit ok);
    tx_data  = b;
    tx_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (tx_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_done(input int snap, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done_cnt > snap) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Device: wait for the host request, then generate n_edges clocks,
  // sampling data on each rising edge; optionally ACK on edge 11.
  task automatic dev_run(input int n_edges, input bit ack, output logic [9:0] bits, output bit seen);
    bits = '0;
    seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (ps2_clk_pin && !ps2_data_pin && busy) begin
        seen = 1'b1;
        break;
      end
    end
    if (seen) begin
      repeat (10) @(negedge clk);
      for (int e = 1; e <= n_edges; e++) begin
        if (e == 11 && ack) begin
          dev_data_low = 1'b1;
          repeat (5) @(negedge clk);
        end
        dev_clk_low = 1'b1;
        dev_edges   = e;
        if (e == 1) dev_first_fall_cyc = cyc;
        repeat (HALF) @(negedge clk);
        dev_clk_low = 1'b0;
        if (e <= 10) bits[e-1] = ps2_data_pin;
        repeat (HALF) @(negedge clk);
      end
    end
    dev_data_low = 1'b0;
  endtask

  logic [9:0] bits_a, bits_b;
  bit         ok_s, ok_d, seen_a, seen_b, reached;
  int         snap, r0;

  initial begin
    rst_n = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    dev_clk_low = 1'b0; dev_data_low = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_clk_oe",  clk_oe,   0);
    check("rst_data_oe", data_oe,  0);
    check("rst_busy",    busy,     0);
    check("rst_done",    tx_done,  0);
    check("rst_err",     tx_err,   0);
    check("rst_ready",   tx_ready, 1);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // 0xF4 with ACK
    snap = done_cnt; r0 = inh_rises;
    fork
      dev_run(11, 1'b1, bits_a, seen_a);
      begin send(8'hF4, ok_s); wait_done(snap, 5000, ok_d); end
    join
    @(negedge clk);
    check("f4_accept",   ok_s, 1);
    check("f4_req_seen", seen_a, 1);
    check("f4_done",     ok_d, 1);
    check("f4_bits",     bits_a, 10'h2F4);
    check("f4_inh_len",  inh_len_last, INH);
    check("f4_inh_cnt",  inh_rises - r0, 1);
    check("f4_err",      err_last, 0);
    check("f4_busy_nxt", busy_after, 0);

    // 0xED then 0x02 back-to-back; VALID held high while busy
    snap = done_cnt;
    fork
      dev_run(11, 1'b1, bits_a, seen_a);
      begin
        send(8'hED, ok_s);
        tx_data = 8'h02; tx_valid = 1'b1;
        wait_done(snap, 5000, ok_d);
      end
    join
    check("ed_done", ok_d, 1);
    check("ed_bits", bits_a, 10'h3ED);
    check("ed_err",  err_last, 0);
    r0 = inh_rises;
    @(negedge clk);
    check("b2b_ready", tx_ready, 1);
    @(negedge clk);
    check("b2b_clk_oe", clk_oe, 1);
    check("b2b_inh_cnt", inh_rises - r0, 1);
    tx_valid = 1'b0;
    snap = done_cnt;
    fork
      dev_run(11, 1'b1, bits_b, seen_b);
      wait_done(snap, 5000, ok_d);
    join
    check("02_done", ok_d, 1);
    check("02_bits", bits_b, 10'h202);
    check("02_err",  err_last, 0);

    // Device never clocks
    repeat (5) @(negedge clk);
    snap = done_cnt; r0 = inh_rises;
    send(8'hFF, ok_s);
    wait_done(snap, 6000, ok_d);
    check("sto_done",    ok_d, 1);
    check("sto_err",     err_last, 1);
    check("sto_cycles",  done_cyc - req_cyc, START);
    check("sto_oe",      oe_at_done, 0);
    check("sto_inh_cnt", inh_rises - r0, NTRIES);

    // NACK on every attempt
    repeat (5) @(negedge clk);
    snap = done_cnt; r0 = inh_rises;
    fork
      for (int t = 0; t < NTRIES; t++) dev_run(11, 1'b0, bits_a, seen_a);
      begin send(8'hF4, ok_s); wait_done(snap, 8000, ok_d); end
    join
    repeat (50) @(negedge clk);
    check("nack_done",    ok_d, 1);
    check("nack_err",     err_last, 1);
    check("nack_inh_cnt", inh_rises - r0, NTRIES);
    check("nack_one_done", done_cnt - snap, 1);

    // Reset during data bit 4 (0xED bit 4 = 0, so DATA_OE is high)
    snap = done_cnt; dev_edges = 0; reached = 1'b0;
    fork
      dev_run(5, 1'b1, bits_a, seen_a);
      begin
        send(8'hED, ok_s);
        for (int i = 0; i < 3000; i++) begin
          @(negedge clk);
          if (dev_edges >= 5) begin reached = 1'b1; break; end
        end
        repeat (8) @(negedge clk);
        check("mid_reached", reached, 1);
        check("mid_data_oe", data_oe, 1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_clk_oe",  clk_oe, 0);
        check("arst_data_oe", data_oe, 0);
        check("arst_ready",   tx_ready, 1);
      end
    join
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    check("arst_no_done", done_cnt - snap, 0);

    // Device stops after edge 5; VALID pulses during transfer are ignored
    snap = done_cnt; r0 = inh_rises; dev_edges = 0;
    fork
      dev_run(5, 1'b1, bits_a, seen_a);
      begin
        send(8'hF4, ok_s);
        for (int i = 0; i < 3000; i++) begin
          @(negedge clk);
          if (dev_edges >= 3) break;
        end
        tx_data = 8'hAA; tx_valid = 1'b1;
        @(negedge clk); tx_valid = 1'b0;
        repeat (40) @(negedge clk);
        tx_valid = 1'b1;
        @(negedge clk); tx_valid = 1'b0;
        wait_done(snap, 8000, ok_d);
      end
    join
`ifndef PS2_TX_RETRY_EN
    check("xto_cycles", done_cyc - dev_first_fall_cyc, XFER + 3);
`endif
    repeat (20) @(negedge clk);
    check("xto_done",     ok_d, 1);
    check("xto_err",      err_last, 1);
    check("xto_oe",       oe_at_done, 0);
    check("xto_inh_cnt",  inh_rises - r0, NTRIES);
    check("xto_one_done", done_cnt - snap, 1);
    check("xto_idle",     busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter: sends one command byte to the keyboard (e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset) using the host-initiated PS/2 sequence.
- Drives open-drain PS2 clock/data enables at top level; shares the PS2_CLK/PS2_DATA pins with the existing keyboard receive path.
- BUSY gates that receive path during a transfer. Runs in the CLK_25MHZ domain.

Parameters:
- INHIBIT_CYCLES, 2500, clock-low hold before start bit (100 us at 25 MHz).
- START_TIMEOUT_CYCLES, 375000, max wait for first device falling edge (15 ms).
- XFER_TIMEOUT_CYCLES, 50000, max time from first device falling edge to ACK completion (2 ms).
- CNT_W, 19, width of the shared timer; must hold the largest cycle parameter.

Ports:
- CLK_25MHZ  in  1  system clock
- RESET_N  in  1  asynchronous active-low reset
- TX_VALID  in  1  command byte offered
- TX_READY  out  1  high only in IDLE
- TX_DATA  in  8  command byte
- PS2_CLK  in  1  raw PS/2 clock pin level
- PS2_DATA  in  1  raw PS/2 data pin level
- PS2_CLK_OE  out  1  1 = pull clock low, 0 = release
- PS2_DATA_OE  out  1  1 = pull data low, 0 = release
- BUSY  out  1  transfer in progress; receiver must ignore frames
- TX_DONE  out  1  one-cycle pulse at transfer end
- TX_ERR  out  1  valid with TX_DONE: 1 = timeout or NACK

Behaviour:
- Reset values:
  - PS2_CLK_OE, PS2_DATA_OE, BUSY, TX_DONE, TX_ERR = 0; TX_READY = 1; state = IDLE.
  - Reset mid-transfer releases both lines immediately (asynchronous).
- Inputs pass through a 2-flop synchronizer. A falling edge is sync_clk 1->0 between consecutive cycles.
- Accept on TX_VALID && TX_READY. Latch frame {stop=1, odd parity, TX_DATA[7:0]}; parity = ~^TX_DATA.
- TX_VALID while not READY is ignored; there is no queue.
- States:
  - IDLE: both OE = 0. On accept -> INHIBIT, timer cleared.
  - INHIBIT: CLK_OE = 1 for INHIBIT_CYCLES. On the last cycle also set DATA_OE = 1 (start bit) -> REQ.
  - REQ: CLK_OE = 0, DATA_OE = 1, timer cleared. Device falling edge -> SHIFT (edge count 0). Timer reaching START_TIMEOUT_CYCLES -> ERR.
  - SHIFT:
    - Timer restarts on entry; timeout at XFER_TIMEOUT_CYCLES -> ERR.
    - Falling edge n (n = 1..10) drives DATA_OE = ~frame[n-1] in the cycle after the edge. Edges 1-8 carry data LSB first, edge 9 parity, edge 10 stop (DATA_OE = 0).
    - Edge 11 samples sync_data: 0 -> RELEASE; 1 -> ERR (NACK).
  - RELEASE: wait for sync_clk = 1 and sync_data = 1 together -> DONE. The XFER timeout still applies -> ERR.
  - DONE: TX_DONE = 1, TX_ERR = 0 for one cycle -> IDLE.
  - ERR: both OE = 0; TX_DONE = 1, TX_ERR = 1 for one cycle -> IDLE.
- BUSY = 1 in every state except IDLE. TX_READY = (state == IDLE), so a new command can be accepted the cycle after TX_DONE.
- Edge count is 4 bits and saturates; the timer is a single CNT_W counter reused across states.
- Best-case latency from accept to the first line change: 1 cycle (CLK_OE rises).

Optional Feature:
- Macro: PS2_TX_RETRY_EN.
- Defined: on timeout or NACK, the block retries the same latched byte from INHIBIT, up to 2 retries. TX_DONE/TX_ERR fire only on success or after the 3rd failure. BUSY stays high across retries. Retry counter is 2 bits, cleared on accept.
- Undefined: the first failure goes straight to ERR.

Decomposition:
- Shared package ps2_pkg:
  - state enum (IDLE, INHIBIT, REQ, SHIFT, RELEASE, DONE, ERR);
  - default timing constants;
  - PS/2 command byte constants (0xED, 0xF4, 0xFF, ACK 0xFA).
- One sub-module, ps2_line_sync: 2-flop synchronizers for clock and data, plus a registered falling-edge pulse.
  - Also reused by the receive path.

Test Plan:
- Send 0xF4; device model clocks at 12.5 kHz and ACKs. Required: CLK_OE high 2500 cycles; device samples data bits 0,0,1,0,1,1,1,1, parity 0, stop 1; TX_DONE pulse with TX_ERR = 0; BUSY low the next cycle.
- Send 0xED. Required: parity bit sampled = 1; TX_DONE with TX_ERR = 0; then immediately send 0x02, accepted the cycle after TX_DONE.
- Device never clocks. Required: TX_ERR = 1 exactly 375000 cycles after REQ entry; both OE = 0.
- Device holds data high on the 11th edge (NACK). Required: TX_ERR = 1; with PS2_TX_RETRY_EN, 3 INHIBIT phases are seen before the single TX_DONE.
- RESET_N low during SHIFT bit 4. Required: both OE = 0 asynchronously; TX_READY = 1; no TX_DONE pulse.
- Device stops clocking after edge 5. Required: TX_ERR = 1 at 50000 cycles after the first edge; TX_VALID pulses during the transfer are ignored.
